// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-to-1 channel mux with valid/ready output.
// Manual mode selects by sel each cycle; scan mode dwells DWELL cycles
// per channel and then captures it, cycling through the channels.
// Optional build macro CHAN_SCAN_MUX_MASK_EN adds a per-channel enable
// mask (ch_mask) honoured by both scan stepping and manual selection.
module chan_scan_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    input  logic                      y_ready,
`ifdef CHAN_SCAN_MUX_MASK_EN
    input  logic [CHANNELS-1:0]       ch_mask,
`endif
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          y_ch,
    output logic                      y_valid,
    output logic                      sel_err
);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_CAP  = 1'b1
    } state_t;

    state_t             state_q;
    logic [15:0]        cnt_q;
    logic [SEL_W-1:0]   ptr_q;
    logic               mode_q;
    logic [WIDTH-1:0]   y_q;
    logic [SEL_W-1:0]   y_ch_q;
    logic               y_valid_q;
    logic               sel_err_q;

    logic [CHANNELS-1:0] en;
    logic                any_en;
    logic                slot_free;
    logic                found_cur;
    logic                found_nxt;
    int unsigned         cur_idx;
    int unsigned         nxt_idx;
    int unsigned         sel_idx;
    logic                man_ok;
    logic [WIDTH-1:0]    man_data;
    logic [WIDTH-1:0]    scan_data;

    assign y       = y_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;
    assign sel_err = sel_err_q;

    // Channel enables, scan channel search and manual select decode
    always_comb begin
`ifdef CHAN_SCAN_MUX_MASK_EN
        en = ch_mask;
`else
        en = '1;
`endif
        any_en    = |en;
        slot_free = !y_valid_q || y_ready;

        // Current scan channel: first enabled channel at or after ptr.
        cur_idx   = int'(ptr_q);
        found_cur = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!found_cur && en[(int'(ptr_q) + i) % CHANNELS]) begin
                cur_idx   = (int'(ptr_q) + i) % CHANNELS;
                found_cur = 1'b1;
            end
        end

        // Next scan channel: first enabled channel strictly after the current one,
        // wrapping back to the current channel when it is the only one enabled.
        nxt_idx   = cur_idx;
        found_nxt = 1'b0;
        for (int unsigned i = 1; i <= CHANNELS; i++) begin
            if (!found_nxt && en[(cur_idx + i) % CHANNELS]) begin
                nxt_idx   = (cur_idx + i) % CHANNELS;
                found_nxt = 1'b1;
            end
        end
        scan_data = din[cur_idx*WIDTH +: WIDTH];

        sel_idx  = int'(sel);
        man_ok   = 1'b0;
        man_data = '0;
        if (sel_idx < CHANNELS) begin
            man_ok = en[sel_idx];
            if (man_ok) begin
                man_data = din[sel_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Output slot, scan FSM and mode tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            mode_q    <= 1'b0;
            y_q       <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            mode_q <= mode;
            // A free slot with no capture this cycle simply drains.
            if (slot_free) begin
                y_valid_q <= 1'b0;
            end

            if (!mode) begin
                // Manual (also covers the cycle scan mode is left).
                state_q <= S_WAIT;
                cnt_q   <= '0;
                if (slot_free) begin
                    y_q       <= man_data;
                    y_ch_q    <= sel;
                    sel_err_q <= !man_ok;
                    y_valid_q <= 1'b1;
                end
            end else if (!mode_q || !any_en) begin
                // Entering scan restarts from channel 0; an empty mask idles.
                if (!mode_q) begin
                    ptr_q <= '0;
                end
                state_q <= S_WAIT;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    S_WAIT: begin
                        cnt_q <= cnt_q + 16'd1;
                        if (cnt_q == 16'(DWELL - 1)) begin
                            state_q <= S_CAP;
                        end
                    end
                    S_CAP: begin
                        if (slot_free) begin
                            y_q       <= scan_data;
                            y_ch_q    <= SEL_W'(cur_idx);
                            sel_err_q <= 1'b0;
                            y_valid_q <= 1'b1;
                            ptr_q     <= SEL_W'(nxt_idx);
                            cnt_q     <= '0;
                            state_q   <= S_WAIT;
                        end
                    end
                    default: state_q <= S_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Bench for chan_scan_mux: two instances (4 ch / DWELL 4 and 3 ch / DWELL 1)
// share stimulus and are compared every cycle against a cycle-level model.
module tb_chan_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din_a;
    logic [23:0] din_b;
    logic [1:0]  sel;
    logic        mode;
    logic        y_ready;

    logic [7:0]  ya, yb;
    logic [1:0]  cha, chb;
    logic        va, vb, ea, eb;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state per instance: index 0 = 4-channel, 1 = 3-channel
    logic [7:0] m_y   [2];
    logic [1:0] m_ch  [2];
    logic       m_v   [2];
    logic       m_e   [2];
    logic       m_prev[2];
    int         m_next[2];
    int         m_age [2];
    int         chans [2] = '{4, 3};
    int         dwell [2] = '{4, 1};

    assign din_b = din_a[23:0];

    always #5 clk = ~clk;

    chan_scan_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(4)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .sel(sel), .mode(mode), .y_ready(y_ready),
`ifdef CHAN_SCAN_MUX_MASK_EN
        .ch_mask(4'b1111),
`endif
        .y(ya), .y_ch(cha), .y_valid(va), .sel_err(ea)
    );

    chan_scan_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .sel(sel), .mode(mode), .y_ready(y_ready),
`ifdef CHAN_SCAN_MUX_MASK_EN
        .ch_mask(3'b111),
`endif
        .y(yb), .y_ch(chb), .y_valid(vb), .sel_err(eb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_y[d] = '0; m_ch[d] = '0; m_v[d] = 1'b0; m_e[d] = 1'b0;
            m_prev[d] = 1'b0; m_next[d] = 0; m_age[d] = 0;
        end
    endtask

    // One clock edge of the reference behaviour, using the inputs held at that edge.
    // Scan timing: a capture is due once DWELL edges have passed since scan entry
    // or the previous capture, and happens on the first edge after that with a free slot.
    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic free, chg;
            free = !m_v[d] || y_ready;
            chg  = (mode != m_prev[d]);
            m_prev[d] = mode;
            if (chg) begin
                m_next[d] = 0;
                m_age[d]  = 0;
            end
            if (free) m_v[d] = 1'b0;
            if (!mode) begin
                if (free) begin
                    m_ch[d] = sel;
                    m_v[d]  = 1'b1;
                    if (int'(sel) < chans[d]) begin
                        m_y[d] = 8'(din_a >> (8 * int'(sel)));
                        m_e[d] = 1'b0;
                    end else begin
                        m_y[d] = 8'h00;
                        m_e[d] = 1'b1;
                    end
                end
            end else if (!chg) begin
                if (m_age[d] >= dwell[d] && free) begin
                    m_y[d]    = 8'(din_a >> (8 * m_next[d]));
                    m_ch[d]   = 2'(m_next[d]);
                    m_e[d]    = 1'b0;
                    m_v[d]    = 1'b1;
                    m_next[d] = (m_next[d] + 1) % chans[d];
                    m_age[d]  = 0;
                end else if (m_age[d] < dwell[d]) begin
                    m_age[d]++;
                end
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".A.y"},     32'(ya),  32'(m_y[0]));
        check({where, ".A.ych"},   32'(cha), 32'(m_ch[0]));
        check({where, ".A.valid"}, 32'(va),  32'(m_v[0]));
        check({where, ".A.err"},   32'(ea),  32'(m_e[0]));
        check({where, ".B.y"},     32'(yb),  32'(m_y[1]));
        check({where, ".B.ych"},   32'(chb), 32'(m_ch[1]));
        check({where, ".B.valid"}, 32'(vb),  32'(m_v[1]));
        check({where, ".B.err"},   32'(eb),  32'(m_e[1]));
    endtask

    task automatic step(input string where, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_edge();
            compare_all(where);
        end
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; y_ready = 1'b1; din_a = 32'hDDCCBBAA;
        #2;
        model_reset();
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Manual sweep with fixed data
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            step("manual", 1);
        end
        check("manual.last.A.y", 32'(ya), 32'hDD);
        check("manual.last.B.err", 32'(eb), 32'h1);

        // Manual backpressure
        sel = 2'd0;
        step("bp.first", 1);
        check("bp.first.A.y", 32'(ya), 32'hAA);
        y_ready = 1'b0; sel = 2'd2;
        step("bp.hold", 3);
        y_ready = 1'b1;
        step("bp.release", 2);

        // Out-of-range select on the 3-channel instance, then back in range
        sel = 2'd3;
        step("oor", 1);
        check("oor.B.ych", 32'(chb), 32'h3);
        sel = 2'd1;
        step("oor.back", 1);

        // Scan with free-running consumer
        mode = 1'b1; y_ready = 1'b1;
        step("scan", 27);

        // Scan under backpressure, then release
        y_ready = 1'b0;
        step("scan.stall", 10);
        y_ready = 1'b1;
        step("scan.resume", 8);

        // Asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst.async");
        @(negedge clk);
        rst = 1'b0;
        step("scan.after_rst", 15);

        // Leave scan, run manual briefly, re-enter scan
        mode = 1'b0; sel = 2'd1;
        step("leave", 3);
        mode = 1'b1;
        step("reenter", 8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            din_a   = $urandom;
            sel     = 2'($urandom_range(0, 3));
            y_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            step("rand", 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
